// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions the start/clear buttons, prescales clk into
// count-enable pulses and sequences the clear of a 9-bit counter.
module stopwatch_ctrl #(
    parameter int unsigned TICKDIV = 50,
    parameter int unsigned CLRLEN  = 2,
    parameter int unsigned WRAP    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_btn,
    input  logic       clr_btn,
    input  logic [8:0] count_in,
    output logic       enable,
    output logic       clear,
    output logic       running,
    output logic       done
);
    // state | meaning
    // CLR   | clear held high for CLRLEN cycles, buttons ignored
    // IDLE  | counter cleared, waiting for start
    // RUN   | prescaler counting, enable pulse every TICKDIV cycles
    // PAUSE | prescaler frozen so the tick phase survives a resume
    // DONE  | counter saturated at 511 (only when WRAP = 0)
    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICKDIV - 1);
    localparam logic [3:0]  CLR_LAST  = 4'(CLRLEN - 1);
    localparam logic [8:0]  COUNT_MAX = 9'd511;

    state_t      state;
    logic [3:0]  clr_cnt;
    logic [15:0] prescaler;
    logic [1:0]  start_sync;
    logic [1:0]  clr_sync;
    logic        start_prev;
    logic        clr_prev;
    logic        start_press;
    logic        clr_press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_sync <= '0;
            clr_sync   <= '0;
            start_prev <= 1'b0;
            clr_prev   <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], start_btn};
            clr_sync   <= {clr_sync[0], clr_btn};
            start_prev <= start_sync[1];
            clr_prev   <= clr_sync[1];
        end
    end

    assign start_press = start_sync[1] & ~start_prev;
    assign clr_press   = clr_sync[1] & ~clr_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_CLR;
            clr_cnt   <= '0;
            prescaler <= '0;
            enable    <= 1'b0;
            clear     <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            enable <= 1'b0;
            // A clear press wins over start; a press during CLR does not restart it.
            if (clr_press && state != S_CLR) begin
                state     <= S_CLR;
                clr_cnt   <= '0;
                prescaler <= '0;
                clear     <= 1'b1;
                running   <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    S_CLR: begin
                        prescaler <= '0;
                        if (clr_cnt == CLR_LAST) begin
                            state   <= S_IDLE;
                            clr_cnt <= '0;
                            clear   <= 1'b0;
                        end else begin
                            clr_cnt <= clr_cnt + 4'd1;
                        end
                    end
                    S_IDLE: begin
                        if (start_press) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (start_press) begin
                            state   <= S_PAUSE;
                            running <= 1'b0;
                        end else if (prescaler == TICK_LAST) begin
                            prescaler <= '0;
                            // Saturate instead of letting the counter roll over.
                            if (WRAP == 0 && count_in == COUNT_MAX) begin
                                state   <= S_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                enable <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 16'd1;
                        end
                    end
                    S_PAUSE: begin
                        if (start_press) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        done <= 1'b1;
                    end
                    default: begin
                        state     <= S_CLR;
                        clr_cnt   <= '0;
                        prescaler <= '0;
                        clear     <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: three instances (run/pause, saturate,
// wrap) each driving a behavioural 9-bit enable/clear counter.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] start_btn = '0;
    logic [2:0] clr_btn = '0;
    logic [2:0] enable;
    logic [2:0] clear;
    logic [2:0] running;
    logic [2:0] done;
    logic [8:0] cnt0 = '0;
    logic [8:0] cnt1 = '0;
    logic [8:0] cnt2 = '0;

    always #10 clk = ~clk;

    stopwatch_ctrl #(.TICKDIV(4), .CLRLEN(2), .WRAP(1)) u_run (
        .clk(clk), .reset_n(reset_n), .start_btn(start_btn[0]), .clr_btn(clr_btn[0]),
        .count_in(cnt0), .enable(enable[0]), .clear(clear[0]), .running(running[0]), .done(done[0]));

    stopwatch_ctrl #(.TICKDIV(2), .CLRLEN(2), .WRAP(0)) u_sat (
        .clk(clk), .reset_n(reset_n), .start_btn(start_btn[1]), .clr_btn(clr_btn[1]),
        .count_in(cnt1), .enable(enable[1]), .clear(clear[1]), .running(running[1]), .done(done[1]));

    stopwatch_ctrl #(.TICKDIV(2), .CLRLEN(2), .WRAP(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .start_btn(start_btn[2]), .clr_btn(clr_btn[2]),
        .count_in(cnt2), .enable(enable[2]), .clear(clear[2]), .running(running[2]), .done(done[2]));

    // Counter stage being controlled.
    always @(posedge clk) begin
        if (clear[0]) cnt0 <= '0; else if (enable[0]) cnt0 <= cnt0 + 9'd1;
        if (clear[1]) cnt1 <= '0; else if (enable[1]) cnt1 <= cnt1 + 9'd1;
        if (clear[2]) cnt2 <= '0; else if (enable[2]) cnt2 <= cnt2 + 9'd1;
    end

    int pcyc = 0;
    int en_q[$];
    bit wrap_seen = 1'b0;
    bit done2_seen = 1'b0;

    always @(posedge clk) begin
        pcyc = pcyc + 1;
        if (enable[0] === 1'b1) en_q.push_back(pcyc);
        if (enable[2] === 1'b1 && cnt2 == 9'd511) wrap_seen = 1'b1;
        if (done[2] === 1'b1) done2_seen = 1'b1;
    end

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    task automatic push(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int obs);
        exp_t e;
        n_asrt++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0;
        int n0;
        int g;
        int bad;

        // Asynchronous reset in the middle of a cycle.
        #15 reset_n = 1'b0;
        #1;
        push("rst_async_clear", 1);  pop_chk(clear[0]);
        push("rst_async_enable", 0); pop_chk(enable[0]);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        push("rst_clear_cycle1", 1); pop_chk(clear[0]);
        tick(1);
        push("rst_clear_done", 0);   pop_chk(clear[0]);
        push("rst_idle_running", 0); pop_chk(running[0]);
        push("rst_idle_done", 0);    pop_chk(done[0]);
        push("rst_count", 0);        pop_chk(cnt0);

        // Start: FSM reacts on the third edge, then pulses every 4 cycles.
        en_q.delete();
        start_btn[0] = 1'b1;
        tick(2);
        push("run_not_yet", 0);      pop_chk(running[0]);
        tick(1);
        push("run_third_edge", 1);   pop_chk(running[0]);
        start_btn[0] = 1'b0;
        t0 = pcyc;
        g = 0;
        while (en_q.size() < 10 && g < 100) begin tick(1); g++; end
        push("run_ten_pulses", 1);   pop_chk(en_q.size() >= 10);
        push("run_first_pulse", t0 + 5);
        pop_chk(en_q.size() > 0 ? en_q[0] : -1);
        bad = 0;
        for (int k = 1; k < en_q.size(); k++) if (en_q[k] - en_q[k-1] != 4) bad++;
        push("run_period_errors", 0); pop_chk(bad);
        push("run_count", 10);        pop_chk(cnt0);

        // Pause so the press lands on the edge where the prescaler holds 2.
        tick(3);
        start_btn[0] = 1'b1;
        tick(3);
        start_btn[0] = 1'b0;
        push("pause_running", 0);    pop_chk(running[0]);
        n0 = en_q.size();
        tick(20);
        push("pause_no_pulse", n0);  pop_chk(en_q.size());
        push("pause_count", 11);     pop_chk(cnt0);

        // Resume keeps the phase: first pulse after two RUN edges.
        n0 = en_q.size();
        start_btn[0] = 1'b1;
        tick(3);
        start_btn[0] = 1'b0;
        push("resume_running", 1);   pop_chk(running[0]);
        t0 = pcyc;
        g = 0;
        while (en_q.size() < n0 + 2 && g < 50) begin tick(1); g++; end
        push("resume_first", t0 + 3);
        pop_chk(en_q.size() > n0 ? en_q[n0] : -1);
        push("resume_period", 4);
        pop_chk(en_q.size() > n0 + 1 ? en_q[n0+1] - en_q[n0] : -1);

        // Saturating and wrapping instances started on the same cycle.
        start_btn[1] = 1'b1;
        start_btn[2] = 1'b1;
        tick(3);
        start_btn[1] = 1'b0;
        start_btn[2] = 1'b0;
        g = 0;
        while (done[1] !== 1'b1 && g < 1200) begin tick(1); g++; end
        push("sat_done", 1);         pop_chk(done[1]);
        push("sat_count", 511);      pop_chk(cnt1);
        push("sat_running", 0);      pop_chk(running[1]);
        push("wrap_pre", 511);       pop_chk(cnt2);
        tick(1);
        push("wrap_count_zero", 0);  pop_chk(cnt2);
        push("wrap_running", 1);     pop_chk(running[2]);
        push("wrap_seen", 1);        pop_chk(wrap_seen);
        tick(10);
        push("sat_hold", 511);       pop_chk(cnt1);
        push("wrap_no_done", 0);     pop_chk(done2_seen);

        start_btn[1] = 1'b1;
        tick(3);
        start_btn[1] = 1'b0;
        tick(1);
        push("sat_start_ignored", 1); pop_chk(done[1]);
        push("sat_still_stopped", 0); pop_chk(running[1]);
        push("sat_still_511", 511);   pop_chk(cnt1);

        clr_btn[1] = 1'b1;
        tick(3);
        clr_btn[1] = 1'b0;
        push("sat_clr_clear", 1);    pop_chk(clear[1]);
        push("sat_clr_done", 0);     pop_chk(done[1]);
        tick(1);
        push("sat_clr_hold", 1);     pop_chk(clear[1]);
        tick(1);
        push("sat_clr_release", 0);  pop_chk(clear[1]);
        push("sat_clr_count", 0);    pop_chk(cnt1);
        push("sat_clr_idle", 0);     pop_chk(running[1]);

        // Simultaneous start and clear while running: clear wins.
        push("prio_pre_running", 1); pop_chk(running[0]);
        start_btn[0] = 1'b1;
        clr_btn[0] = 1'b1;
        tick(3);
        start_btn[0] = 1'b0;
        clr_btn[0] = 1'b0;
        push("prio_clear", 1);       pop_chk(clear[0]);
        push("prio_running", 0);     pop_chk(running[0]);
        push("prio_enable", 0);      pop_chk(enable[0]);
        tick(2);
        push("prio_release", 0);     pop_chk(clear[0]);
        push("prio_count", 0);       pop_chk(cnt0);
        push("prio_idle", 0);        pop_chk(running[0]);

        // Reset asserted while an enable pulse is high.
        tick(3);
        start_btn[0] = 1'b1;
        tick(3);
        start_btn[0] = 1'b0;
        g = 0;
        while (enable[0] !== 1'b1 && g < 20) begin tick(1); g++; end
        push("rst_pulse_seen", 1);   pop_chk(enable[0]);
        #2 reset_n = 1'b0;
        #1;
        push("rst_mid_enable", 0);   pop_chk(enable[0]);
        push("rst_mid_clear", 1);    pop_chk(clear[0]);
        push("rst_mid_running", 0);  pop_chk(running[0]);
        tick(1);
        reset_n = 1'b1;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control stage directly upstream of the 9-bit enable/clear counter. It conditions raw start/stop and clear buttons, prescales the system clock into one-cycle count-enable pulses, and sequences the counter's clear. It reads the counter value back so it can saturate at 511 when wrap is disabled. Drives `enable` and `clear` of the counter; `running` and `done` go to the display/LED logic.

Parameters:
TICKDIV, 50, clk cycles per enable pulse while running; legal range 2..65535.
CLRLEN, 2, cycles `clear` is held high per clear sequence; legal range 1..15.
WRAP, 1, 1 = counter allowed to wrap 511->0; 0 = stop at 511 and enter DONE.

Ports:
clk  in  1  system clock; rising edge active.
reset_n  in  1  asynchronous, active-low reset.
start_btn  in  1  raw start/stop button, asynchronous to clk, active high.
clr_btn  in  1  raw clear button, asynchronous to clk, active high.
count_in  in  9  counter value fed back from the counter stage.
enable  out  1  registered one-cycle count-advance pulse to the counter.
clear  out  1  registered active-high clear to the counter.
running  out  1  high while in RUN.
done  out  1  high while in DONE.

Behaviour:
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a registered previous-value flop.
  - The press pulse is `sync2 & ~prev`, one cycle wide.
  - The FSM acts on the 3rd rising edge after the raw input is first sampled high.
  - Holding a button generates no further pulses. Release needs no handling.
- States: CLR, IDLE, RUN, PAUSE, DONE. All state and output registers reset asynchronously.
- Reset (reset_n = 0), applied immediately with no clock needed:
  - state = CLR, clr_cnt = 0, prescaler = 0.
  - enable = 0, clear = 1, running = 0, done = 0.
  - Synchronizer flops reset to 0.
- CLR: `clear` = 1; clr_cnt increments each cycle. After CLRLEN cycles with `clear` high, go to IDLE and `clear` = 0. Prescaler is forced to 0. Button pulses are ignored.
- IDLE: `enable` = 0. start press -> RUN. clr press -> CLR.
- RUN:
  - Prescaler increments every cycle.
  - At the edge where prescaler == TICKDIV-1: prescaler <= 0 and `enable` <= 1 for exactly one cycle; otherwise `enable` <= 0.
  - Result: pulse period is exactly TICKDIV cycles.
  - start press -> PAUSE, prescaler holds its value.
  - clr press -> CLR.
- PAUSE:
  - `enable` = 0, prescaler frozen.
  - start press -> RUN, resuming from the frozen prescaler value, so the phase is preserved.
  - clr press -> CLR.
- Saturation (WRAP = 0 only): in RUN, if prescaler == TICKDIV-1 and count_in == 511, go to DONE with no enable pulse. The counter therefore holds 511.
- DONE: `enable` = 0, `done` = 1. start press ignored. clr press -> CLR.
- With WRAP = 1, DONE is unreachable; the counter wraps on its own.
- Simultaneous start and clr press in any state: clr wins (-> CLR).
- clr press while already in CLR: ignored; the sequence is not restarted.
- Timing:
  - count_in settles up to 15 ns after clk; minimum clk period is 20 ns.
  - TICKDIV >= 2 guarantees count_in is stable when compared.
- Widths: prescaler is 16 bits. Compare against TICKDIV-1 as an unsigned constant.

Test Plan:
- Reset: TICKDIV=4, CLRLEN=2. Assert reset_n=0 mid-cycle -> clear=1 and enable=0 with no clock edge. Release -> clear stays 1 for 2 cycles, then 0; state IDLE; counter = 0.
- Run: start press -> running=1 on the 3rd edge. enable pulses exactly every 4 cycles, one cycle wide. After 10 pulses the counter reads 10.
- Pause/resume: pause when prescaler = 2 -> enable stays 0 for 20 cycles and count frozen. Resume -> first enable pulse after 2 RUN edges (not 4); later pulses every 4 cycles.
- Saturate: WRAP=0, TICKDIV=2, run to count 511 -> done=1, no further enable, count stays 511. start ignored. clr press -> clear 2 cycles, count 0, IDLE, done=0.
- Wrap: WRAP=1, TICKDIV=2, run past 511 -> count goes 511 -> 0, running stays 1, done never asserted.
- Priority/reset mid-op: start and clr pressed in the same cycle during RUN -> CLR, enable 0, count 0, then IDLE. reset_n pulsed low during an enable pulse -> enable drops to 0 asynchronously and clear=1.
